// File: rtl/w_schedule_stream.sv
// Streaming SHA-256/SHA-512 message schedule: one 16-word block in, W[0..NUM_ROUNDS-1] out.
// Optional W_VECTOR_OUT_EN adds a flattened copy of the emitted words (w_vector, w_vector_complete).
module w_schedule_stream #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_ROUNDS = 64,
  parameter int IDX_W      = $clog2(NUM_ROUNDS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     msg_valid,
  output logic                     msg_ready,
  input  logic [16*WORD_WIDTH-1:0] message_block,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [WORD_WIDTH-1:0]    w_word,
  output logic [IDX_W-1:0]         w_index,
  output logic                     w_last
`ifdef W_VECTOR_OUT_EN
  ,
  output logic [NUM_ROUNDS*WORD_WIDTH-1:0] w_vector,
  output logic                             w_vector_complete
`endif
);

  localparam int W = WORD_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  if (!(WORD_WIDTH == 32 || WORD_WIDTH == 64)) begin : g_bad_width
    $error("w_schedule_stream: WORD_WIDTH must be 32 or 64");
  end
  if (NUM_ROUNDS < 16 || NUM_ROUNDS > 255) begin : g_bad_rounds
    $error("w_schedule_stream: NUM_ROUNDS must be in 16..255");
  end

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] sig0(input logic [W-1:0] x);
    if (W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else         return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [W-1:0] sig1(input logic [W-1:0] x);
    if (W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else         return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state, state_nxt;
  logic [15:0][W-1:0]  win;
  logic [IDX_W-1:0]    cnt;
  logic [W-1:0]        w_new;
  logic                is_last, w_hs, m_hs, adv;

  assign is_last = (cnt == LAST_IDX);
  assign w_hs    = w_valid && w_ready;
  assign m_hs    = msg_valid && msg_ready;
  assign adv     = w_hs && !is_last;
  // win[0] is the word on the output; win[15] receives W[t+16]
  assign w_new   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    msg_ready = 1'b0;
    w_valid   = 1'b0;
    case (state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_nxt = STREAM;
      end
      STREAM: begin
        w_valid = 1'b1;
        if (w_ready && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_word  = win[0];
  assign w_index = cnt;
  assign w_last  = w_valid && is_last;

  // Counter returns to 0 on the last word so IDLE always shows index 0
  always_ff @(posedge clock) begin
    if (reset)              cnt <= '0;
    else if (m_hs)          cnt <= '0;
    else if (w_hs) begin
      if (is_last)          cnt <= '0;
      else                  cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_win
    always_ff @(posedge clock) begin
      if (reset)     win[i] <= '0;
      else if (m_hs) win[i] <= message_block[(15-i)*W +: W];
      else if (adv)  win[i] <= (i == 15) ? w_new : win[(i+1) % 16];
    end
  end

`ifdef W_VECTOR_OUT_EN
  logic [NUM_ROUNDS-1:0][W-1:0] vec;
  logic                         vec_done;

  // Slot t sits at vec[NUM_ROUNDS-1-t] so W[0] lands in the MSBs
  always_ff @(posedge clock) begin
    if (reset) begin
      vec      <= '0;
      vec_done <= 1'b0;
    end else begin
      vec_done <= w_hs && is_last;
      if (w_hs) vec[LAST_IDX - cnt] <= win[0];
    end
  end

  assign w_vector          = vec;
  assign w_vector_complete = vec_done;
`endif

endmodule
